move_rx: RTL and testbench

MOVE_RX -- requirements
Module: move_rx

---
 rtl/move_rx_pkg.sv | 26 ++
 rtl/move_rx_samp_tick_gen.sv | 44 ++++
 rtl/move_rx.sv | 150 +++++++++++++++
 tb/tb_move_rx.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/move_rx_pkg.sv
// rtl/move_rx_pkg.sv - shared state encoding and default timing constants for move_rx
// MOVE_RX_PARITY_EN adds the PARITY state.
package move_rx_pkg;

  localparam int DEF_CLK_PER_SAMP  = 423;
  localparam int DEF_SAMP_PER_BIT  = 16;
  localparam int DEF_PKT_LEN       = 8;
  localparam int DEF_WAITING_COUNT = 65_000;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef MOVE_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } rx_state_t;

  // Width of a counter that runs 0..terminal-1, never narrower than one bit.
  function automatic int cnt_width(input int terminal);
    return (terminal > 1) ? $clog2(terminal) : 1;
  endfunction

endpackage

// File: rtl/move_rx_samp_tick_gen.sv
// rtl/move_rx_samp_tick_gen.sv - rx synchronizer and oversample tick generator
module samp_tick_gen
  import move_rx_pkg::*;
#(
  parameter int CLK_PER_SAMP = DEF_CLK_PER_SAMP
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic rx,
  input  logic restart,
  output logic rx_sync,
  output logic tick
);

  localparam int CW = cnt_width(CLK_PER_SAMP);
  localparam logic [CW-1:0] TICK_LAST = CW'(CLK_PER_SAMP - 1);

  logic          rx_meta;
  logic [CW-1:0] div_cnt;

  // Flops reset high so a released reset looks like an idle line.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      div_cnt <= '0;
    end else if (restart || div_cnt == TICK_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign tick = (div_cnt == TICK_LAST);

endmodule

// File: rtl/move_rx.sv
// rtl/move_rx.sv - oversampling async serial receiver with line-idle arming
// Define MOVE_RX_PARITY_EN to expect an even-parity bit before the stop bit.
module move_rx
  import move_rx_pkg::*;
#(
  parameter int CLK_PER_SAMP  = DEF_CLK_PER_SAMP,
  parameter int SAMP_PER_BIT  = DEF_SAMP_PER_BIT,
  parameter int PKT_LEN       = DEF_PKT_LEN,
  parameter int WAITING_COUNT = DEF_WAITING_COUNT
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rx,
  output logic               ready,
  output logic [PKT_LEN-1:0] data_out,
  output logic               frame_err
);

  localparam int SW = cnt_width(SAMP_PER_BIT);
  localparam int BW = cnt_width(PKT_LEN);
  localparam int HW = cnt_width(WAITING_COUNT);
  localparam logic [SW-1:0] HALF_LAST = SW'(SAMP_PER_BIT / 2 - 1);
  localparam logic [SW-1:0] SAMP_LAST = SW'(SAMP_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(PKT_LEN - 1);
  localparam logic [HW-1:0] HUNT_LAST = HW'(WAITING_COUNT - 1);

  rx_state_t          state, state_d;
  logic               rx_sync, tick, rx_prev;
  logic               restart, fall, bit_mid;
  logic               shift_en, load_out, err_set;
  logic [SW-1:0]      samp_cnt;
  logic [BW-1:0]      bit_cnt;
  logic [HW-1:0]      hunt_cnt;
  logic [PKT_LEN-1:0] shreg;

  samp_tick_gen #(.CLK_PER_SAMP(CLK_PER_SAMP)) u_tick (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .rx      (rx),
    .restart (restart),
    .rx_sync (rx_sync),
    .tick    (tick)
  );

  assign fall    = rx_prev & ~rx_sync;
  assign bit_mid = tick && (samp_cnt == SAMP_LAST);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= ST_HUNT;
    else        state <= state_d;
  end

  always_comb begin
    state_d  = state;
    restart  = 1'b0;
    shift_en = 1'b0;
    load_out = 1'b0;
    err_set  = 1'b0;
    case (state)
      ST_HUNT: begin
        if (rx_sync && hunt_cnt == HUNT_LAST) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (fall) begin
          restart = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        // A line back high at the start mid-point was only a glitch.
        if (tick && samp_cnt == HALF_LAST) state_d = rx_sync ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (bit_mid) begin
          shift_en = 1'b1;
`ifdef MOVE_RX_PARITY_EN
          if (bit_cnt == BIT_LAST) state_d = ST_PARITY;
`else
          if (bit_cnt == BIT_LAST) state_d = ST_STOP;
`endif
        end
      end
`ifdef MOVE_RX_PARITY_EN
      ST_PARITY: begin
        if (bit_mid) begin
          if (rx_sync != ^shreg) begin
            err_set = 1'b1;
            state_d = ST_HUNT;
          end else begin
            state_d = ST_STOP;
          end
        end
      end
`endif
      ST_STOP: begin
        // Leaving at the stop mid-point lets a back-to-back start edge be seen.
        if (bit_mid) begin
          if (rx_sync) begin
            load_out = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            err_set = 1'b1;
            state_d = ST_HUNT;
          end
        end
      end
      default: state_d = ST_HUNT;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rx_prev  <= 1'b1;
      hunt_cnt <= '0;
      samp_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      data_out <= '0;
      ready    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_prev   <= rx_sync;
      ready     <= load_out;
      frame_err <= err_set;

      if (state == ST_HUNT && rx_sync && hunt_cnt != HUNT_LAST) hunt_cnt <= hunt_cnt + 1'b1;
      else                                                     hunt_cnt <= '0;

      // The start half-bit and each full bit both end with the count back at 0.
      if (restart) begin
        samp_cnt <= '0;
      end else if (tick) begin
        if (samp_cnt == SAMP_LAST || (state == ST_START && samp_cnt == HALF_LAST))
          samp_cnt <= '0;
        else
          samp_cnt <= samp_cnt + 1'b1;
      end

      if (restart) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
      end

      if (shift_en) shreg <= {rx_sync, shreg[PKT_LEN-1:1]};
      if (load_out) data_out <= shreg;
    end
  end

endmodule

// File: tb/tb_move_rx.sv
// tb/tb_move_rx.sv - randomized and directed bench for move_rx against a frame-level model
// MOVE_RX_PARITY_EN enables the parity-error step.
module tb_move_rx;

  localparam int CPS   = 4;
  localparam int SPB   = 8;   // keeps one high data bit (32 cycles) under the 50-cycle arming wait
  localparam int WAITC = 50;
  localparam int BITC  = CPS * SPB;
  localparam int REARM = WAITC + 10;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       rx;
  logic       ready;
  logic       frame_err;
  logic [7:0] data_out;

  int         total = 0;
  int         bad = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         fe_seen = 0;
  int         exp_fe = 0;
  int         both_seen = 0;
  int         drift_seen = 0;
  bit         armed;
  logic [7:0] last_good;
  logic [7:0] prev_out = 8'h00;
`ifdef MOVE_RX_PARITY_EN
  bit         flip_par = 1'b0;
`endif

  move_rx #(
    .CLK_PER_SAMP  (CPS),
    .SAMP_PER_BIT  (SPB),
    .PKT_LEN       (8),
    .WAITING_COUNT (WAITC)
  ) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rx        (rx),
    .ready     (ready),
    .data_out  (data_out),
    .frame_err (frame_err)
  );

  always #5 clk_in = ~clk_in;

  always begin
    @(posedge clk_in);
    #1;
    if (ready) got_q.push_back(data_out);
    if (frame_err) fe_seen++;
    if (ready && frame_err) both_seen++;
    if (!rst_in && !ready && data_out !== prev_out) drift_seen++;
    prev_out = data_out;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_sb(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, "_data"}, got_q[i], exp_q[i]);
    check({tag, "_ferr"}, fe_seen, exp_fe);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk_in);
    if (n >= REARM) armed = 1'b1;
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (BITC) @(negedge clk_in);
  endtask

  // Model: an armed receiver accepts a good frame; a bad one costs one
  // frame_err and disarms it until the line idles long enough.
  task automatic send_frame(input logic [7:0] d, input logic stop_v);
    bit ok;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    ok = stop_v;
`ifdef MOVE_RX_PARITY_EN
    drive_bit(^d ^ flip_par);
    ok = ok && !flip_par;
`endif
    drive_bit(stop_v);
    rx = 1'b1;
    if (armed) begin
      if (ok) begin
        exp_q.push_back(d);
        last_good = d;
      end else begin
        exp_fe++;
        armed = 1'b0;
      end
    end
  endtask

  initial begin
    logic [7:0] rd;
    logic [7:0] c3;
    rst_in    = 1'b1;
    rx        = 1'b1;
    armed     = 1'b0;
    last_good = 8'h00;
    repeat (3) @(negedge clk_in);
    check("rst_ready", ready, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_data", data_out, 0);
    rst_in = 1'b0;

    idle(60);
    send_frame(8'hA5, 1'b1);
    idle(20);
    check_sb("a5");
    check("a5_out", data_out, last_good);

    rx = 1'b0;
    repeat (2 * CPS) @(negedge clk_in);
    idle(40);
    check_sb("glitch");
    send_frame(8'h3C, 1'b1);
    idle(20);
    check_sb("after_glitch");

    send_frame(8'h55, 1'b0);
    idle(20);
    check_sb("bad_stop");
    check("bad_stop_hold", data_out, last_good);
    send_frame(8'h12, 1'b1);
    idle(REARM);
    check_sb("hunt_ignore");
    send_frame(8'h12, 1'b1);
    idle(20);
    check_sb("rearmed");

    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(20);
    check_sb("b2b");

    c3 = 8'hC3;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(c3[i]);
    rx = c3[4];
    repeat (BITC / 2) @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    check("mid_rst_ready", ready, 0);
    check("mid_rst_ferr", frame_err, 0);
    check("mid_rst_data", data_out, 0);
    repeat (2) @(negedge clk_in);
    rx        = 1'b1;
    rst_in    = 1'b0;
    armed     = 1'b0;
    last_good = 8'h00;
    idle(REARM);
    check_sb("mid_rst");
    check("mid_rst_hold", data_out, last_good);
    send_frame(8'h81, 1'b1);
    idle(20);
    check_sb("after_rst");

`ifdef MOVE_RX_PARITY_EN
    flip_par = 1'b1;
    send_frame(8'h07, 1'b1);
    flip_par = 1'b0;
    idle(20);
    check_sb("parity");
    check("parity_hold", data_out, last_good);
    idle(REARM);
`endif

    for (int n = 0; n < 12; n++) begin
      rd = 8'($urandom);
      send_frame(rd, 1'b1);
      idle(int'($urandom_range(0, 20)));
    end
    idle(20);
    check_sb("random");
    check("random_out", data_out, last_good);

    check("ready_with_ferr", both_seen, 0);
    check("data_drift", drift_seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
